// File: rtl/core_inst_decoder.sv
// Core-side instruction decoder: registers one-hot strobes from the controller word,
// tracks the Q write -> K write -> K load -> execute phases and latches the first protocol error.
module core_inst_decoder #(
    parameter int Q_DEPTH = 16,
    parameter int K_DEPTH = 16,
    parameter int LD_LEN  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [18:0] inst_in,
    output logic        q_wr_en,
    output logic        q_rd_en,
    output logic        k_wr_en,
    output logic        k_rd_en,
    output logic        p_wr_en,
    output logic        p_rd_en,
    output logic [3:0]  qk_addr_o,
    output logic [3:0]  p_addr_o,
    output logic        mac_load,
    output logic        mac_exec,
    output logic        ofifo_rd,
    output logic [1:0]  sfp_op_o,
    output logic        q_full,
    output logic        k_full,
    output logic        ld_done,
    output logic [2:0]  phase,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_QW   = 3'd1;
    localparam logic [2:0] PH_KW   = 3'd2;
    localparam logic [2:0] PH_LD   = 3'd3;
    localparam logic [2:0] PH_EX   = 3'd4;

    // Control bits only; the two address fields never count as out-of-phase.
    localparam logic [18:0] CTRL_BITS = 19'h700FF;
    localparam logic [18:0] MASK_QW   = 19'h00010;
    localparam logic [18:0] MASK_KW   = 19'h00004;
    localparam logic [18:0] MASK_LD   = 19'h00048;
    localparam logic [18:0] MASK_EX   = 19'h700A3;

    localparam logic [4:0] Q_TOP  = 5'(Q_DEPTH);
    localparam logic [4:0] K_TOP  = 5'(K_DEPTH);
    localparam logic [4:0] LD_TOP = 5'(LD_LEN);

    logic [1:0] f_sfp;
    logic       f_ofifo, f_ex, f_ld, f_qrd, f_qwr, f_krd, f_kwr, f_prd, f_pwr;
    logic [3:0] f_qka, f_pa;

    assign f_sfp   = inst_in[18:17];
    assign f_ofifo = inst_in[16];
    assign f_qka   = inst_in[15:12];
    assign f_pa    = inst_in[11:8];
    assign f_ex    = inst_in[7];
    assign f_ld    = inst_in[6];
    assign f_qrd   = inst_in[5];
    assign f_qwr   = inst_in[4];
    assign f_krd   = inst_in[3];
    assign f_kwr   = inst_in[2];
    assign f_prd   = inst_in[1];
    assign f_pwr   = inst_in[0];

    logic [4:0]  q_cnt, k_cnt, ld_cnt;
    logic [4:0]  q_cnt_nxt, k_cnt_nxt, ld_cnt_nxt;
    logic [2:0]  ph_nxt;
    logic [18:0] legal;
    logic        oop, both, sfp_bad, q_addr_bad, k_addr_bad, rd_addr_bad;
    logic        q_live, k_live, ld_live;
    logic [2:0]  code;
    logic        s_q_wr, s_q_rd, s_k_wr, s_k_rd, s_p_wr, s_p_rd;
    logic        s_load, s_exec, s_ofifo;
    logic [1:0]  s_sfp;

    // Next phase first: a word that triggers a transition is judged in the new phase.
    always_comb begin
        ph_nxt = phase;
        case (phase)
            PH_IDLE: if (f_qwr)            ph_nxt = PH_QW;
            PH_QW:   if (f_kwr && q_full)  ph_nxt = PH_KW;
            PH_KW:   if (f_ld && k_full)   ph_nxt = PH_LD;
            PH_LD:   if (f_ex && ld_done)  ph_nxt = PH_EX;
            default: ph_nxt = phase;
        endcase
    end

    always_comb begin
        case (ph_nxt)
            PH_QW:   legal = MASK_QW;
            PH_KW:   legal = MASK_KW;
            PH_LD:   legal = MASK_LD;
            PH_EX:   legal = MASK_EX;
            default: legal = '0;
        endcase
    end

    // Once a count is complete, further writes/loads in that phase are absorbed silently.
    assign q_live  = (ph_nxt == PH_QW) && !q_full;
    assign k_live  = (ph_nxt == PH_KW) && !k_full;
    assign ld_live = (ph_nxt == PH_LD) && !ld_done;

    assign oop         = |(inst_in & CTRL_BITS & ~legal);
    assign both        = f_qwr && f_kwr;
    assign sfp_bad     = (f_sfp == 2'b11);
    assign q_addr_bad  = f_qwr && q_live  && (f_qka != q_cnt[3:0]);
    assign k_addr_bad  = f_kwr && k_live  && (f_qka != k_cnt[3:0]);
    assign rd_addr_bad = f_krd && ld_live && (f_qka != ld_cnt[3:0]);

    always_comb begin
        if (oop)                                        code = 3'd1;
        else if (q_addr_bad || k_addr_bad || rd_addr_bad) code = 3'd2;
        else if (both)                                  code = 3'd3;
        else if (sfp_bad)                               code = 3'd4;
        else                                            code = 3'd0;
    end

    // An out-of-phase word is dropped whole; other errors drop only the offending strobe.
    always_comb begin
        s_q_wr  = !oop && f_qwr && q_live && !q_addr_bad && !both;
        s_k_wr  = !oop && f_kwr && k_live && !k_addr_bad && !both;
        s_load  = !oop && f_ld  && ld_live;
        s_k_rd  = !oop && f_krd && ld_live && !rd_addr_bad;
        s_exec  = !oop && f_ex    && (ph_nxt == PH_EX);
        s_q_rd  = !oop && f_qrd   && (ph_nxt == PH_EX);
        s_p_rd  = !oop && f_prd   && (ph_nxt == PH_EX);
        s_p_wr  = !oop && f_pwr   && (ph_nxt == PH_EX);
        s_ofifo = !oop && f_ofifo && (ph_nxt == PH_EX);
        s_sfp   = (!oop && !sfp_bad && (ph_nxt == PH_EX)) ? f_sfp : 2'b00;
    end

    assign q_cnt_nxt  = q_cnt  + 5'(s_q_wr);
    assign k_cnt_nxt  = k_cnt  + 5'(s_k_wr);
    assign ld_cnt_nxt = ld_cnt + 5'(s_load && s_k_rd);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase     <= PH_IDLE;
            q_cnt     <= '0;
            k_cnt     <= '0;
            ld_cnt    <= '0;
            q_full    <= 1'b0;
            k_full    <= 1'b0;
            ld_done   <= 1'b0;
            q_wr_en   <= 1'b0;
            q_rd_en   <= 1'b0;
            k_wr_en   <= 1'b0;
            k_rd_en   <= 1'b0;
            p_wr_en   <= 1'b0;
            p_rd_en   <= 1'b0;
            mac_load  <= 1'b0;
            mac_exec  <= 1'b0;
            ofifo_rd  <= 1'b0;
            sfp_op_o  <= 2'b00;
            qk_addr_o <= '0;
            p_addr_o  <= '0;
            err       <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            phase     <= ph_nxt;
            q_cnt     <= q_cnt_nxt;
            k_cnt     <= k_cnt_nxt;
            ld_cnt    <= ld_cnt_nxt;
            // Counters only climb to their top, so these stay set once reached.
            q_full    <= (q_cnt_nxt  == Q_TOP);
            k_full    <= (k_cnt_nxt  == K_TOP);
            ld_done   <= (ld_cnt_nxt == LD_TOP);
            q_wr_en   <= s_q_wr;
            q_rd_en   <= s_q_rd;
            k_wr_en   <= s_k_wr;
            k_rd_en   <= s_k_rd;
            p_wr_en   <= s_p_wr;
            p_rd_en   <= s_p_rd;
            mac_load  <= s_load;
            mac_exec  <= s_exec;
            ofifo_rd  <= s_ofifo;
            sfp_op_o  <= s_sfp;
            qk_addr_o <= f_qka;
            p_addr_o  <= f_pa;
            if (!err && (code != 3'd0)) begin
                err      <= 1'b1;
                err_code <= code;
            end
        end
    end

endmodule

// File: tb/tb_core_inst_decoder.sv
// Directed bench for core_inst_decoder: each step pushes its expected outputs to a
// scoreboard queue, which is popped and compared one cycle after the word is sampled.
module tb_core_inst_decoder;

    localparam logic [2:0] PH_IDLE = 3'd0, PH_QW = 3'd1, PH_KW = 3'd2, PH_LD = 3'd3, PH_EX = 3'd4;

    localparam logic [18:0] W_PWR = 19'h00001, W_PRD = 19'h00002, W_KWR = 19'h00004,
                            W_KRD = 19'h00008, W_QWR = 19'h00010, W_QRD = 19'h00020,
                            W_LD  = 19'h00040, W_EX  = 19'h00080, W_OF  = 19'h10000;

    // Strobe vector order: {sfp_op[1:0], ofifo, exec, load, q_rd, q_wr, k_rd, k_wr, p_rd, p_wr}
    localparam logic [10:0] S_NONE = 11'h000, S_PWR = 11'h001, S_PRD = 11'h002, S_KWR = 11'h004,
                            S_KRD  = 11'h008, S_QWR = 11'h010, S_QRD = 11'h020, S_MLD = 11'h040,
                            S_MEX  = 11'h080, S_OF  = 11'h100, S_SFP1 = 11'h200;

    typedef struct packed {
        logic [10:0] strb;
        logic [3:0]  qk;
        logic [3:0]  pa;
        logic [2:0]  flags;
        logic [2:0]  ph;
        logic        err;
        logic [2:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [18:0] inst_in = '0;
    logic        q_wr_en, q_rd_en, k_wr_en, k_rd_en, p_wr_en, p_rd_en;
    logic [3:0]  qk_addr_o, p_addr_o;
    logic        mac_load, mac_exec, ofifo_rd;
    logic [1:0]  sfp_op_o;
    logic        q_full, k_full, ld_done;
    logic [2:0]  phase;
    logic        err;
    logic [2:0]  err_code;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    core_inst_decoder #(.Q_DEPTH(16), .K_DEPTH(16), .LD_LEN(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .inst_in(inst_in),
        .q_wr_en(q_wr_en), .q_rd_en(q_rd_en), .k_wr_en(k_wr_en), .k_rd_en(k_rd_en),
        .p_wr_en(p_wr_en), .p_rd_en(p_rd_en), .qk_addr_o(qk_addr_o), .p_addr_o(p_addr_o),
        .mac_load(mac_load), .mac_exec(mac_exec), .ofifo_rd(ofifo_rd), .sfp_op_o(sfp_op_o),
        .q_full(q_full), .k_full(k_full), .ld_done(ld_done), .phase(phase),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] qk(input int a);
        return 19'(a & 15) << 12;
    endfunction

    function automatic logic [18:0] pa(input int a);
        return 19'(a & 15) << 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Drive one word (optionally with reset/clear), push its expectation, compare after the edge.
    task automatic step(input string tag, input logic [18:0] w, input logic rst, input logic clr,
                        input logic [10:0] strb, input logic [2:0] flags, input logic [2:0] ph,
                        input logic e, input logic [2:0] c);
        exp_t x, got;
        @(negedge clk);
        inst_in = w;
        reset   = rst;
        clear   = clr;
        x.strb  = strb;
        x.qk    = (rst || clr) ? 4'h0 : w[15:12];
        x.pa    = (rst || clr) ? 4'h0 : w[11:8];
        x.flags = flags;
        x.ph    = ph;
        x.err   = e;
        x.code  = c;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".strobes"}, 32'({sfp_op_o, ofifo_rd, mac_exec, mac_load, q_rd_en, q_wr_en,
                                     k_rd_en, k_wr_en, p_rd_en, p_wr_en}), 32'(got.strb));
        check({tag, ".qk_addr"}, 32'(qk_addr_o), 32'(got.qk));
        check({tag, ".p_addr"},  32'(p_addr_o),  32'(got.pa));
        check({tag, ".flags"},   32'({q_full, k_full, ld_done}), 32'(got.flags));
        check({tag, ".phase"},   32'(phase), 32'(got.ph));
        check({tag, ".err"},     32'({err, err_code}), 32'({got.err, got.code}));
        inst_in = '0;
        reset   = 1'b0;
        clear   = 1'b0;
    endtask

    initial begin
        // Reset wins over a live word.
        step("rst0", '0, 1'b1, 1'b0, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);
        step("rst1", W_QWR | qk(3), 1'b1, 1'b0, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);
        step("nop", '0, 1'b0, 1'b0, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);

        for (int i = 0; i < 16; i++)
            step("qwr", W_QWR | qk(i), 1'b0, 1'b0, S_QWR, (i == 15) ? 3'b100 : 3'b000, PH_QW, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++)
            step("qovr", W_QWR | qk(i), 1'b0, 1'b0, S_NONE, 3'b100, PH_QW, 1'b0, 3'd0);
        for (int i = 0; i < 16; i++)
            step("kwr", W_KWR | qk(i), 1'b0, 1'b0, S_KWR, (i == 15) ? 3'b110 : 3'b100, PH_KW, 1'b0, 3'd0);
        step("kovr", W_KWR | qk(0), 1'b0, 1'b0, S_NONE, 3'b110, PH_KW, 1'b0, 3'd0);

        for (int i = 0; i < 3; i++)
            step("ldonly", W_LD, 1'b0, 1'b0, S_MLD, 3'b110, PH_LD, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++)
            step("ldrd", W_LD | W_KRD | qk(i), 1'b0, 1'b0, S_MLD | S_KRD, (i == 7) ? 3'b111 : 3'b110,
                 PH_LD, 1'b0, 3'd0);
        step("ldovr", W_LD | W_KRD | qk(0), 1'b0, 1'b0, S_NONE, 3'b111, PH_LD, 1'b0, 3'd0);
        step("exec", W_EX, 1'b0, 1'b0, S_MEX, 3'b111, PH_EX, 1'b0, 3'd0);
        step("exmix", W_QRD | W_PRD | W_OF | (19'd1 << 17) | pa(9), 1'b0, 1'b0,
             S_QRD | S_PRD | S_OF | S_SFP1, 3'b111, PH_EX, 1'b0, 3'd0);
        step("sfp11", W_PWR | (19'd3 << 17) | pa(5), 1'b0, 1'b0, S_PWR, 3'b111, PH_EX, 1'b1, 3'd4);
        step("clear", W_EX, 1'b0, 1'b1, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);
        step("postclr", '0, 1'b0, 1'b0, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);

        step("qw_a", W_QWR | qk(0), 1'b0, 1'b0, S_QWR, 3'b000, PH_QW, 1'b0, 3'd0);
        step("oop_kwr", W_KWR | qk(0), 1'b0, 1'b0, S_NONE, 3'b000, PH_QW, 1'b1, 3'd1);
        step("badaddr", W_QWR | qk(5), 1'b0, 1'b0, S_NONE, 3'b000, PH_QW, 1'b1, 3'd1);
        step("qw_b", W_QWR | qk(1), 1'b0, 1'b0, S_QWR, 3'b000, PH_QW, 1'b1, 3'd1);

        step("rst2", '0, 1'b1, 1'b0, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);
        for (int i = 0; i < 16; i++)
            step("qwr2", W_QWR | qk(i), 1'b0, 1'b0, S_QWR, (i == 15) ? 3'b100 : 3'b000, PH_QW, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++)
            step("kwr2", W_KWR | qk(i), 1'b0, 1'b0, S_KWR, 3'b100, PH_KW, 1'b0, 3'd0);
        step("midrst", W_KWR | qk(5), 1'b1, 1'b0, S_NONE, 3'b000, PH_IDLE, 1'b0, 3'd0);
        step("qw_c", W_QWR | qk(0), 1'b0, 1'b0, S_QWR, 3'b000, PH_QW, 1'b0, 3'd0);
        step("addr2", W_QWR | qk(7), 1'b0, 1'b0, S_NONE, 3'b000, PH_QW, 1'b1, 3'd2);
        step("ldidle", W_LD, 1'b0, 1'b0, S_NONE, 3'b000, PH_QW, 1'b1, 3'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
